// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sequencer states, opcode constants and instruction field positions
package cpu_pkg;
  typedef enum logic [2:0] {S_LOAD, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [3:0] OP_LDR  = 4'b1000;
  localparam logic [3:0] OP_STR  = 4'b1001;
  localparam logic [3:0] OP_B    = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam int COND_LSB  = 28;
  localparam int OPC_LSB   = 24;
  localparam int S_BIT     = 23;
  localparam int DEST_LSB  = 19;
  localparam int SRC1_LSB  = 15;
  localparam int SRC2_LSB  = 11;
  localparam int SHAMT_LSB = 6;
  localparam int IMM_LSB   = 3;
  localparam int SHCTL_LSB = 0;
endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// cpu_seq_ctrl_if: instruction and data memory request/acknowledge handshakes
interface cpu_seq_ctrl_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  modport master (output imem_req, imem_addr, dmem_req, dmem_we, input imem_ack, imem_rdata, dmem_ack);
  modport slave (input imem_req, imem_addr, dmem_req, dmem_we, output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute/mem/writeback sequencer owning pc and ir.
// Define CPU_SEQ_BRANCH_EN to make OP_B load pc from the immediate instead of acting as a NOP.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  cpu_seq_ctrl_if.master bus,
  input  logic          cond_met,
  output logic [3:0]    cond_o,
  output logic [3:0]    opcode_o,
  output logic          s_o,
  output logic [3:0]    dest_o,
  output logic [3:0]    src1_o,
  output logic [3:0]    src2_o,
  output logic [4:0]    shamt_o,
  output logic [2:0]    shctl_o,
  output logic [15:0]   imm_o,
  output logic          reg_we,
  output logic          ldr_sel,
  output logic          addr_sel,
  output logic          retire,
  output logic          halted
);
  state_t          state, nxt;
  logic [PC_W-1:0] pc, pc_nxt, pc_inc, pc_exec;
  logic [31:0]     ir;
  assign cond_o        = ir[COND_LSB +: 4];
  assign opcode_o      = ir[OPC_LSB +: 4];
  assign s_o           = ir[S_BIT];
  assign dest_o        = ir[DEST_LSB +: 4];
  assign src1_o        = ir[SRC1_LSB +: 4];
  assign src2_o        = ir[SRC2_LSB +: 4];
  assign shamt_o       = ir[SHAMT_LSB +: 5];
  assign shctl_o       = ir[SHCTL_LSB +: 3];
  assign imm_o         = ir[IMM_LSB +: 16];
  assign pc_inc        = pc + PC_W'(1);
  assign bus.imem_addr = pc;
`ifdef CPU_SEQ_BRANCH_EN
  assign pc_exec = (opcode_o == OP_B) ? imm_o[PC_W-1:0] : pc_inc;
`else
  assign pc_exec = pc_inc;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_LOAD;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= nxt;
      pc    <= pc_nxt;
      if (state == S_FETCH && bus.imem_ack) ir <= bus.imem_rdata;
    end
  end
  // requests and strobes are pure functions of state, so an async reset drops them at once
  always_comb begin
    nxt          = state;
    pc_nxt       = pc;
    reg_we       = 1'b0;
    ldr_sel      = 1'b0;
    addr_sel     = 1'b0;
    retire       = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    halted       = state == S_HALT;
    case (state)
      S_LOAD: nxt = S_FETCH;
      S_FETCH: begin
        bus.imem_req = 1'b1;
        nxt          = bus.imem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        retire = cond_o != 4'd0 && !cond_met;
        pc_nxt = retire ? pc_inc : pc;
        nxt    = retire ? S_FETCH : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (opcode_o == OP_LDR || opcode_o == OP_STR) nxt = S_MEM;
        else if (opcode_o == OP_HALT) nxt = S_HALT;
        else begin
          reg_we = opcode_o != OP_B;
          retire = 1'b1;
          pc_nxt = pc_exec;
          nxt    = S_FETCH;
        end
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        addr_sel     = 1'b1;
        bus.dmem_we  = opcode_o == OP_STR;
        retire       = bus.dmem_ack && bus.dmem_we;
        pc_nxt       = retire ? pc_inc : pc;
        nxt          = !bus.dmem_ack ? S_MEM : bus.dmem_we ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we  = 1'b1;
        ldr_sel = 1'b1;
        retire  = 1'b1;
        pc_nxt  = pc_inc;
        nxt     = S_FETCH;
      end
      default: nxt = state;
    endcase
  end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: randomized instruction stream with variable memory waits against a per-instruction model
module tb_cpu_seq_ctrl;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic cond_met;
  logic [3:0] cond_o, opcode_o, dest_o, src1_o, src2_o;
  logic s_o, reg_we, ldr_sel, addr_sel, retire, halted;
  logic [4:0] shamt_o;
  logic [2:0] shctl_o;
  logic [15:0] imm_o;
  cpu_seq_ctrl_if #(.PC_W(8)) bus ();
  cpu_seq_ctrl #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .cond_met(cond_met),
    .cond_o(cond_o), .opcode_o(opcode_o), .s_o(s_o), .dest_o(dest_o), .src1_o(src1_o),
    .src2_o(src2_o), .shamt_o(shamt_o), .shctl_o(shctl_o), .imm_o(imm_o), .reg_we(reg_we),
    .ldr_sel(ldr_sel), .addr_sel(addr_sel), .retire(retire), .halted(halted)
  );
  logic [3:0] c4, o4, d4, a4, b4;
  logic s4, we4, ls4, as4, rt4, h4;
  logic [4:0] sh4;
  logic [2:0] sc4;
  logic [15:0] im4;
  int r4;
  cpu_seq_ctrl_if #(.PC_W(4)) bus4 ();
  assign bus4.imem_ack   = bus4.imem_req;
  assign bus4.imem_rdata = 32'h0100_0000;
  assign bus4.dmem_ack   = 1'b0;
  cpu_seq_ctrl #(.PC_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.master), .cond_met(1'b1),
    .cond_o(c4), .opcode_o(o4), .s_o(s4), .dest_o(d4), .src1_o(a4),
    .src2_o(b4), .shamt_o(sh4), .shctl_o(sc4), .imm_o(im4), .reg_we(we4),
    .ldr_sel(ls4), .addr_sel(as4), .retire(rt4), .halted(h4)
  );
  always @(posedge clk or negedge rst)
    if (!rst) r4 <= 0;
    else if (rt4) r4 <= r4 + 1;
  logic [7:0] mpc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // drives one instruction through fetch to retire and compares its observable footprint
  task automatic run(input logic [31:0] w, input logic cm, input int iw, input int dw);
    logic [3:0] op = w[27:24];
    bit skip = (w[31:28] != 4'd0) && !cm;
    bit is_ld = !skip && op == OP_LDR;
    bit is_st = !skip && op == OP_STR;
    int exp_lat = iw + (skip ? 2 : is_ld ? 5 + dw : is_st ? 4 + dw : 3);
    int exp_we = (!skip && op != OP_STR && op != OP_B) ? 1 : 0;
    int n = 0, ic = 0, dc = 0, mem_n = 0, st_n = 0, we_n = 0, ld_n = 0;
    bit done = 0, bad = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      bus.imem_ack   = bus.imem_req ? (ic == iw) : ($urandom_range(3) == 0);
      bus.imem_rdata = (bus.imem_req && ic == iw) ? w : $urandom;
      bus.dmem_ack   = bus.dmem_req ? (dc == dw) : ($urandom_range(3) == 0);
      cond_met       = cm;
      #1;
      if (bus.imem_req && n == 0) chk("fetch_pc", 32'(bus.imem_addr), 32'(mpc));
      if (bus.imem_req || n > 0) n++;
      if (bus.imem_req) ic++;
      if (bus.dmem_req) begin
        dc++;
        mem_n++;
        st_n += int'(bus.dmem_we);
      end
      if (reg_we) begin
        we_n++;
        ld_n += int'(ldr_sel);
      end
      bad |= (bus.imem_req && bus.dmem_req) || (addr_sel != bus.dmem_req) || halted;
      if (retire) begin
        done = 1;
        chk("fields", {cond_o, opcode_o, s_o, dest_o, src1_o, src2_o, shamt_o, 3'b000, shctl_o},
            {w[31:6], 3'b000, w[2:0]});
        chk("imm", 32'(imm_o), 32'(w[18:3]));
      end
    end
    chk("retired", 32'(done), 1);
    chk("latency", n, exp_lat);
    chk("reg_we_count", we_n, exp_we);
    chk("ldr_sel_count", ld_n, int'(is_ld));
    chk("dmem_cycles", mem_n, (is_ld || is_st) ? dw + 1 : 0);
    chk("store_cycles", st_n, is_st ? dw + 1 : 0);
    chk("bus_rules", 32'(bad), 0);
`ifdef CPU_SEQ_BRANCH_EN
    mpc = (!skip && op == OP_B) ? w[10:3] : mpc + 8'd1;
`else
    mpc = mpc + 8'd1;
`endif
  endtask
  initial begin
    logic [31:0] w;
    logic [3:0] op, cnd;
    int r;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack = 1'b0;
    cond_met = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_reqs", {bus.imem_req, bus.dmem_req, addr_sel, reg_we, retire, halted}, 0);
    chk("rst_pc", 32'(bus.imem_addr), 0);
    chk("rst_ir", {cond_o, opcode_o, imm_o}, 0);
    @(negedge clk);
    rst = 1'b1;
    mpc = 8'd0;
    run(32'h0123_4567, 1'b1, 0, 0);
    run({4'h0, OP_LDR, 24'h3A_5C71}, 1'b1, 2, 3);
    run({4'h1, 4'h2, 24'h12_3456}, 1'b0, 0, 0);
    run({4'h1, OP_STR, 24'hF0_0F0F}, 1'b1, 1, 2);
    run({4'h0, OP_B, 5'h00, 16'h0025, 3'h0}, 1'b1, 0, 0);
    run({4'h2, OP_B, 5'h00, 16'h0011, 3'h0}, 1'b0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      r   = $urandom_range(9);
      op  = r < 6 ? 4'($urandom_range(7)) : r == 6 ? OP_LDR : r == 7 ? OP_STR : OP_B;
      cnd = $urandom_range(1) ? 4'($urandom_range(15)) : 4'd0;
      w   = {cnd, op, 24'($urandom)};
      run(w, 1'($urandom_range(1)), $urandom_range(3), $urandom_range(3));
    end
    w = {4'h0, OP_HALT, 24'hAB_CDEF};
    for (int cyc = 0; cyc < 10 && !halted; cyc++) begin
      @(negedge clk);
      bus.imem_ack = bus.imem_req;
      bus.imem_rdata = w;
      bus.dmem_ack = 1'b0;
      #1;
    end
    chk("halt_reached", 32'(halted), 1);
    bus.imem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.imem_ack = 1'($urandom_range(1));
      bus.dmem_ack = 1'($urandom_range(1));
      #1;
      chk("halt_hold", {halted, bus.imem_req, bus.dmem_req, retire, reg_we}, 32'b10000);
      chk("halt_pc", 32'(bus.imem_addr), 32'(mpc));
    end
    rst = 1'b0;
    #1;
    chk("halt_exit", 32'(halted), 0);
    @(negedge clk);
    rst = 1'b1;
    mpc = 8'd0;
    run(32'h0300_0000, 1'b0, 0, 0);
    run(32'h0400_0000, 1'b0, 1, 0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    chk("held_req", {31'd0, bus.imem_req}, 1);
    chk("held_pc", 32'(bus.imem_addr), 2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_req", {bus.imem_req, bus.dmem_req, retire, halted}, 0);
    chk("abort_pc", 32'(bus.imem_addr), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("load_no_req", 32'(bus.imem_req), 0);
    mpc = 8'd0;
    run({4'h0, OP_STR, 24'h00_0001}, 1'b0, 0, 1);
    r = 0;
    for (int cyc = 0; cyc < 200 && r == 0; cyc++) begin
      @(negedge clk);
      #1;
      if (rt4 && bus4.imem_addr == 4'd15) r = 1;
    end
    chk("pc4_reach15", r, 1);
    @(negedge clk);
    #1;
    chk("pc4_wrap", 32'(bus4.imem_addr), 0);
    chk("pc4_count", 32'(bus4.imem_addr), 32'(r4 % 16));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
